// File: rtl/multi_digit_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : multi_digit_display_driver
// Brief    : Time-multiplexed hex 7-segment driver with per-slot PWM, digit
//            blink and leading-zero blanking; display updates are frame-synced.
// Revision : 1.0 - initial release
// ============================================================================
module multi_digit_display_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_TO     = 100_000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    val_valid_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    blank_lz_in,
    input  logic [3:0]              brightness_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done_out
);

    localparam int          c_slot_w = $clog2(COUNT_TO + 1);
    localparam int          c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          c_frm_w  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned c_step   = (COUNT_TO + 1) >> 4;

    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(COUNT_TO);
    localparam logic [c_slot_w-1:0] c_slot_pre  = c_slot_w'(COUNT_TO - 1);
    localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one   = c_idx_w'(1);
    localparam logic [c_frm_w-1:0]  c_frm_last  = c_frm_w'(BLINK_FRAMES - 1);
    localparam logic [c_frm_w-1:0]  c_frm_one   = c_frm_w'(1);

    // Scan state
    logic [c_slot_w-1:0]     r_slot_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_frm_w-1:0]      r_frame_cnt;
    logic                    r_blink_phase;
    logic [3:0]              r_level;
    logic                    r_frame_done;

    // Pending (host side) and display (scan side) copies of the content
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic                    r_pend_blank_lz;
    logic                    r_pend_vld;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_disp_blink;
    logic                    r_disp_blank_lz;

    // Registered pin drivers
    logic [6:0]              r_cat;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_slot_wrap;
    logic                    w_boundary;
    logic [3:0]              w_level;
    logic                    w_pwm_on;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_dark_sel;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_slot_wrap = (r_slot_cnt == c_slot_last);
    assign w_boundary  = w_slot_wrap && (r_idx == c_idx_last);

    // The level for slot 0 comes straight from the pin so the whole slot uses it
    assign w_level  = (r_slot_cnt == '0) ? brightness_in : r_level;
    assign w_pwm_on = (w_level == 4'hF) ||
                      (32'(r_slot_cnt) < (32'(w_level) * c_step));

    // Walk from the top digit down so zero_above covers nibbles i..NUM_DIGITS-1
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_dark     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (r_disp_val[4*i +: 4] == 4'h0);
            w_dark[i]  = r_disp_blink[i] & r_blink_phase;
            if ((i > 0) && r_disp_blank_lz && zero_above) begin
                w_dark[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_an_sel   = '0;
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_dark_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_an_sel[i] = 1'b1;
                w_nib       = r_disp_val[4*i +: 4];
                w_dp_sel    = r_disp_dp[i];
                w_dark_sel  = w_dark[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_level       <= 4'h0;
            r_frame_done  <= 1'b0;
        end else begin
            // Pre-decoded so the pulse coincides with the boundary cycle itself
            r_frame_done <= (r_slot_cnt == c_slot_pre) && (r_idx == c_idx_last);
            if (r_slot_cnt == '0) begin
                r_level <= brightness_in;
            end
            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_one;
            end else begin
                r_slot_cnt <= r_slot_cnt + c_slot_one;
            end
            if (w_boundary) begin
                if (r_frame_cnt == c_frm_last) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_frm_one;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend_val      <= '0;
            r_pend_dp       <= '0;
            r_pend_blink    <= '0;
            r_pend_blank_lz <= 1'b0;
            r_pend_vld      <= 1'b0;
            r_disp_val      <= '0;
            r_disp_dp       <= '0;
            r_disp_blink    <= '0;
            r_disp_blank_lz <= 1'b0;
        end else begin
            if (val_valid_in) begin
                r_pend_val      <= val_in;
                r_pend_dp       <= dp_in;
                r_pend_blink    <= blink_in;
                r_pend_blank_lz <= blank_lz_in;
                r_pend_vld      <= 1'b1;
            end
            if (w_boundary) begin
                r_pend_vld <= 1'b0;
                if (val_valid_in) begin
                    r_disp_val      <= val_in;
                    r_disp_dp       <= dp_in;
                    r_disp_blink    <= blink_in;
                    r_disp_blank_lz <= blank_lz_in;
                end else if (r_pend_vld) begin
                    r_disp_val      <= r_pend_val;
                    r_disp_dp       <= r_pend_dp;
                    r_disp_blink    <= r_pend_blink;
                    r_disp_blank_lz <= r_pend_blank_lz;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_an  <= '1;
            r_cat <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= '1;
            r_cat <= 7'h7F;
            r_dp  <= 1'b1;
            if (w_pwm_on && !w_dark_sel) begin
                r_an  <= ~w_an_sel;
                r_cat <= ~hex_to_seg(w_nib);
                r_dp  <= ~w_dp_sel;
            end
        end
    end

    assign cat_out        = r_cat;
    assign dp_out         = r_dp;
    assign an_out         = r_an;
    assign frame_done_out = r_frame_done;

endmodule
`default_nettype wire

// File: doc/multi_digit_display_driver.md
MULTI_DIGIT_DISPLAY_DRIVER -- requirements
Module: multi_digit_display_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: digit count, legal range 1..16.
REQ-002 SHALL have parameter COUNT_TO, default 100_000: last slot-counter value, so one digit slot lasts COUNT_TO+1 cycles; minimum 15.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period, minimum 1.
REQ-004 SHALL have port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port val_in, input, 4*NUM_DIGITS bits: hex value; nibble i drives digit i, and digit 0 = bits [3:0].
REQ-007 SHALL have port val_valid_in, input, 1 bit: capture strobe for val_in, dp_in, blink_in and blank_lz_in.
REQ-008 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point for each digit, active-high.
REQ-009 SHALL have port blink_in, input, NUM_DIGITS bits: blink enable for each digit.
REQ-010 SHALL have port blank_lz_in, input, 1 bit: leading-zero blanking enable.
REQ-011 SHALL have port brightness_in, input, 4 bits: duty level, where 0 = off and 15 = full.
REQ-012 SHALL have port cat_out, output, 7 bits: segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 SHALL have port dp_out, output, 1 bit: decimal-point cathode, active-low.
REQ-014 SHALL have port an_out, output, NUM_DIGITS bits: digit anodes, active-low, at most one bit low at a time.
REQ-015 SHALL have port frame_done_out, output, 1 bit: one-cycle pulse when a scan frame ends.

Function
REQ-016 SHALL count slot_cnt 0..COUNT_TO; on wrap, digit index advances i -> i+1, and NUM_DIGITS-1 wraps to 0.
REQ-017 SHALL treat the cycle where slot_cnt=COUNT_TO and index=NUM_DIGITS-1 as the frame boundary, with frame_done_out high for exactly that cycle (registered).
REQ-018 SHALL latch val/dp/blink/blank_lz into a pending register when val_valid_in=1; the last strobe in a frame wins.
REQ-019 SHALL copy pending into the display register only at the frame boundary; no mid-frame tearing.
REQ-020 SHALL load a strobe coinciding with the frame boundary directly into the display register in that cycle.
REQ-021 SHALL leave the display register unchanged at the boundary if no strobe occurred that frame.
REQ-022 SHALL sample brightness_in at each slot start (slot_cnt=0) and hold it for that slot.
REQ-023 SHALL enable the anode when (level=15) or (slot_cnt < level*((COUNT_TO+1)>>4)); level=0 means never enabled.
REQ-024 SHALL count frames with a frame counter 0..BLINK_FRAMES-1, toggling blink_phase on wrap.
REQ-025 SHALL blank digit i while blink_phase=1 if blink bit i=1.
REQ-026 SHALL blank digit i>0 when blank_lz=1 and nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be LZ-blanked.
REQ-027 SHALL drive a blanked or PWM-off digit as an_out all ones, cat_out=7'h7F, dp_out=1.
REQ-028 SHALL decode hex with the standard 0-F patterns (active-high 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71), then invert onto cat_out.
REQ-029 SHALL register cat_out, dp_out and an_out, with one cycle latency from the slot/index state.
REQ-030 SHALL keep all counters modular with no overflow: slot_cnt width = clog2(COUNT_TO+1), index width = clog2(NUM_DIGITS) with minimum 1.

Reset
REQ-031 SHALL, while rst_n_in=0 and asynchronously, force an_out all ones, cat_out=7'h7F, dp_out=1 and frame_done_out=0.
REQ-032 SHALL, while rst_n_in=0, clear slot_cnt, index, frame counter, blink_phase, pending and display registers to 0.
REQ-033 SHALL, when reset asserts mid-slot, blank outputs immediately.
REQ-034 SHALL, after reset release, resume scanning at digit 0 with slot_cnt=0, and the display SHALL show 0 on digit 0 until the first update.

Verification (NUM_DIGITS=4, COUNT_TO=15, BLINK_FRAMES=2)
REQ-035 SHALL cover basic scan: val_in=16'h12AF with a strobe and brightness 15 -> after the next boundary, an_out walks 1110,1101,1011,0111 at 16 cycles each, cat_out=~7'h71,~7'h77,~7'h5B,~7'h06, and frame_done_out pulses every 64 cycles.
REQ-036 SHALL cover no tearing: a strobe of 16'h5555 at mid-frame while showing 16'h12AF -> remaining digits still show 12AF, and 5555 appears starting with digit 0 of the next frame.
REQ-037 SHALL cover leading-zero blanking: 16'h0030 with blank_lz=1 -> digits 3 and 2 are dark, digit 1 shows 3 and digit 0 shows 0; 16'h0000 -> only digit 0 is lit.
REQ-038 SHALL cover PWM: brightness 4 -> anode low for 4 of 16 cycles per slot; brightness 0 -> an_out stays 4'hF.
REQ-039 SHALL cover blink: blink_in=4'b0010 -> digit 1 is lit for 2 frames and dark for 2 frames, repeating, while other digits are unaffected.
REQ-040 SHALL cover async reset: rst_n_in pulled low for 3 cycles mid-slot with no clock edge -> outputs go blank at once, and scan restarts at digit 0 after release.
